// File: rtl/cond_logic.sv
// cond_logic: conditional-execution stage of the multicycle ARM datapath.
// Holds the architectural NZCV flags, evaluates the instruction condition
// field against them, and gates the state-changing strobes from the control
// unit so that only condition-passing instructions modify PC, registers or
// memory.
module cond_logic (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] Rd,
    input  logic [3:0] Cmd,
    input  logic       S,
    input  logic [3:0] ALUFlags,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       NextPC,
    input  logic       Branch,
    input  logic       ALUOp,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [3:0] Flags,
    output logic       CondExQ
);

    // Condition field encodings
    localparam logic [3:0] CondEq = 4'b0000;
    localparam logic [3:0] CondNe = 4'b0001;
    localparam logic [3:0] CondCs = 4'b0010;
    localparam logic [3:0] CondCc = 4'b0011;
    localparam logic [3:0] CondMi = 4'b0100;
    localparam logic [3:0] CondPl = 4'b0101;
    localparam logic [3:0] CondVs = 4'b0110;
    localparam logic [3:0] CondVc = 4'b0111;
    localparam logic [3:0] CondHi = 4'b1000;
    localparam logic [3:0] CondLs = 4'b1001;
    localparam logic [3:0] CondGe = 4'b1010;
    localparam logic [3:0] CondLt = 4'b1011;
    localparam logic [3:0] CondGt = 4'b1100;
    localparam logic [3:0] CondLe = 4'b1101;
    localparam logic [3:0] CondAl = 4'b1110;

    // Data-processing opcodes that also produce meaningful C/V
    localparam logic [3:0] CmdAdd = 4'b0100;
    localparam logic [3:0] CmdSub = 4'b0010;

    // Register-file index of the PC
    localparam logic [3:0] RegPc = 4'b1111;

    logic [3:0] flags_q;
    logic       cond_ex_q;
    logic       cond_ex;
    logic [1:0] flag_w;
    logic       pcs;
    logic       flag_n;
    logic       flag_z;
    logic       flag_c;
    logic       flag_v;

    assign flag_n = flags_q[3];
    assign flag_z = flags_q[2];
    assign flag_c = flags_q[1];
    assign flag_v = flags_q[0];

    // Evaluate the condition field against the current architectural flags
    always_comb begin
        cond_ex = 1'b1;
        unique case (Cond)
            CondEq:  cond_ex = flag_z;
            CondNe:  cond_ex = ~flag_z;
            CondCs:  cond_ex = flag_c;
            CondCc:  cond_ex = ~flag_c;
            CondMi:  cond_ex = flag_n;
            CondPl:  cond_ex = ~flag_n;
            CondVs:  cond_ex = flag_v;
            CondVc:  cond_ex = ~flag_v;
            CondHi:  cond_ex = flag_c & ~flag_z;
            CondLs:  cond_ex = ~flag_c | flag_z;
            CondGe:  cond_ex = (flag_n == flag_v);
            CondLt:  cond_ex = (flag_n != flag_v);
            CondGt:  cond_ex = ~flag_z & (flag_n == flag_v);
            CondLe:  cond_ex = flag_z | (flag_n != flag_v);
            CondAl:  cond_ex = 1'b1;
            // Reserved 1111 executes unconditionally
            default: cond_ex = 1'b1;
        endcase
    end

    // Decode which flag groups this instruction may write; logical ops
    // with S set touch only N/Z and leave C/V untouched
    always_comb begin
        flag_w    = 2'b00;
        flag_w[1] = ALUOp & S;
        flag_w[0] = ALUOp & S & ((Cmd == CmdAdd) | (Cmd == CmdSub));
    end

    // Architectural flags and the registered condition-pass bit; both use
    // the pre-edge flags, so new flags influence CondEx from the next cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q   <= 4'b0000;
            cond_ex_q <= 1'b0;
        end else begin
            if (flag_w[1] && cond_ex) begin
                flags_q[3:2] <= ALUFlags[3:2];
            end
            if (flag_w[0] && cond_ex) begin
                flags_q[1:0] <= ALUFlags[1:0];
            end
            cond_ex_q <= cond_ex;
        end
    end

    // Gate state-changing strobes; the fetch increment is never gated
    always_comb begin
        pcs      = Branch | (RegW & (Rd == RegPc));
        PCWrite  = (pcs & cond_ex_q) | NextPC;
        RegWrite = RegW & cond_ex_q;
        MemWrite = MemW & cond_ex_q;
    end

    assign Flags   = flags_q;
    assign CondExQ = cond_ex_q;

endmodule

// File: tb/tb_cond_logic.sv
// Directed testbench for cond_logic.
module tb_cond_logic;

    logic       clk;
    logic       reset;
    logic [3:0] Cond;
    logic [3:0] Rd;
    logic [3:0] Cmd;
    logic       S;
    logic [3:0] ALUFlags;
    logic       RegW;
    logic       MemW;
    logic       NextPC;
    logic       Branch;
    logic       ALUOp;
    logic       PCWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic [3:0] Flags;
    logic       CondExQ;

    int checks;
    int errors;

    cond_logic dut (
        .clk      (clk),
        .reset    (reset),
        .Cond     (Cond),
        .Rd       (Rd),
        .Cmd      (Cmd),
        .S        (S),
        .ALUFlags (ALUFlags),
        .RegW     (RegW),
        .MemW     (MemW),
        .NextPC   (NextPC),
        .Branch   (Branch),
        .ALUOp    (ALUOp),
        .PCWrite  (PCWrite),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite),
        .Flags    (Flags),
        .CondExQ  (CondExQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // One rising edge, then settle so outputs are sampled away from the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ctrl();
        RegW   = 1'b0;
        MemW   = 1'b0;
        NextPC = 1'b0;
        Branch = 1'b0;
        ALUOp  = 1'b0;
        S      = 1'b0;
        Cmd    = 4'b0000;
        Rd     = 4'b0000;
    endtask

    // Load arbitrary flags using an unconditional ADDS
    task automatic load_flags(input logic [3:0] f);
        idle_ctrl();
        Cond     = 4'b1110;
        ALUOp    = 1'b1;
        S        = 1'b1;
        Cmd      = 4'b0100;
        ALUFlags = f;
        step();
        ALUOp    = 1'b0;
        S        = 1'b0;
    endtask

    // Condition table written directly from the architectural definition
    function automatic logic cond_model(input logic [3:0] f, input logic [3:0] c);
        logic n, z, cf, v;
        n  = f[3];
        z  = f[2];
        cf = f[1];
        v  = f[0];
        case (c)
            4'd0:    return z;
            4'd1:    return !z;
            4'd2:    return cf;
            4'd3:    return !cf;
            4'd4:    return n;
            4'd5:    return !n;
            4'd6:    return v;
            4'd7:    return !v;
            4'd8:    return cf && !z;
            4'd9:    return !cf || z;
            4'd10:   return n == v;
            4'd11:   return n != v;
            4'd12:   return !z && (n == v);
            4'd13:   return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    initial begin
        checks   = 0;
        errors   = 0;
        idle_ctrl();
        ALUFlags = 4'b0000;

        // Reset with strobes requested
        reset  = 1'b0;
        Cond   = 4'b1110;
        RegW   = 1'b1;
        MemW   = 1'b1;
        Branch = 1'b1;
        step();
        step();
        check_val("rst_regwrite", {3'b0, RegWrite}, 4'd0);
        check_val("rst_memwrite", {3'b0, MemWrite}, 4'd0);
        check_val("rst_pcwrite", {3'b0, PCWrite}, 4'd0);
        check_val("rst_flags", Flags, 4'b0000);
        check_val("rst_condexq", {3'b0, CondExQ}, 4'd0);

        // Release away from an edge, then one AL edge
        @(negedge clk);
        reset = 1'b1;
        step();
        check_val("rel_condexq", {3'b0, CondExQ}, 4'd1);
        check_val("rel_regwrite", {3'b0, RegWrite}, 4'd1);
        check_val("rel_memwrite", {3'b0, MemWrite}, 4'd1);
        check_val("rel_pcwrite", {3'b0, PCWrite}, 4'd1);

        // ADDS sets all four flags
        load_flags(4'b0110);
        check_val("adds_flags", Flags, 4'b0110);
        RegW = 1'b1;
        #1;
        check_val("adds_regwrite", {3'b0, RegWrite}, 4'd1);

        // ANDS keeps C/V
        load_flags(4'b0011);
        check_val("pre_ands_flags", Flags, 4'b0011);
        ALUOp    = 1'b1;
        S        = 1'b1;
        Cmd      = 4'b0000;
        ALUFlags = 4'b1000;
        step();
        check_val("ands_flags", Flags, 4'b1011);

        // ORRS likewise keeps C/V
        Cmd      = 4'b1100;
        ALUFlags = 4'b0100;
        step();
        check_val("orrs_flags", Flags, 4'b0111);

        // ADD without S leaves flags alone
        S        = 1'b0;
        Cmd      = 4'b0100;
        ALUFlags = 4'b1000;
        step();
        check_val("add_nos_flags", Flags, 4'b0111);

        // SUBS updates C/V too
        S        = 1'b1;
        Cmd      = 4'b0010;
        ALUFlags = 4'b1001;
        step();
        check_val("subs_flags", Flags, 4'b1001);

        // Condition fails: no flag update, strobes blocked, NextPC passes
        load_flags(4'b0000);
        Cond     = 4'b0000;
        ALUOp    = 1'b1;
        S        = 1'b1;
        Cmd      = 4'b0100;
        ALUFlags = 4'b0100;
        step();
        check_val("fail_flags", Flags, 4'b0000);
        check_val("fail_condexq", {3'b0, CondExQ}, 4'd0);
        ALUOp  = 1'b0;
        S      = 1'b0;
        RegW   = 1'b1;
        MemW   = 1'b1;
        Branch = 1'b1;
        #1;
        check_val("fail_regwrite", {3'b0, RegWrite}, 4'd0);
        check_val("fail_memwrite", {3'b0, MemWrite}, 4'd0);
        check_val("fail_pcwrite_branch", {3'b0, PCWrite}, 4'd0);
        Branch = 1'b0;
        NextPC = 1'b1;
        #1;
        check_val("fail_pcwrite_nextpc", {3'b0, PCWrite}, 4'd1);

        // Writes to R15 drive PCWrite through CondExQ
        load_flags(4'b0100);
        Cond = 4'b0000;
        RegW = 1'b1;
        Rd   = 4'b1111;
        step();
        check_val("pcs_eq_pcwrite", {3'b0, PCWrite}, 4'd1);
        Cond = 4'b0001;
        step();
        check_val("pcs_ne_pcwrite", {3'b0, PCWrite}, 4'd0);
        Rd   = 4'b0011;
        Cond = 4'b0000;
        step();
        check_val("rd_nonpc_pcwrite", {3'b0, PCWrite}, 4'd0);
        check_val("rd_nonpc_regwrite", {3'b0, RegWrite}, 4'd1);

        // Flag-setting instruction decides its writeback on pre-update flags
        load_flags(4'b0000);
        Cond     = 4'b0001;
        ALUOp    = 1'b1;
        S        = 1'b1;
        Cmd      = 4'b0010;
        ALUFlags = 4'b0110;
        step();
        check_val("self_flags", Flags, 4'b0110);
        check_val("self_condexq", {3'b0, CondExQ}, 4'd1);

        // Spot checks for the signed comparisons
        load_flags(4'b1001);
        Cond = 4'b1010;
        step();
        check_val("ge_n1v1", {3'b0, CondExQ}, 4'd1);
        load_flags(4'b1000);
        Cond = 4'b1101;
        step();
        check_val("le_z0n1v0", {3'b0, CondExQ}, 4'd1);

        // Full sweep of flags x condition codes
        for (int f = 0; f < 16; f++) begin
            for (int c = 0; c < 16; c++) begin
                load_flags(4'(f));
                Cond = 4'(c);
                step();
                check_val($sformatf("sweep_f%0h_c%0h", f, c), {3'b0, CondExQ},
                          {3'b0, cond_model(4'(f), 4'(c))});
            end
        end

        // Asynchronous reset mid-instruction
        load_flags(4'b1111);
        idle_ctrl();
        Cond = 4'b1110;
        step();
        RegW = 1'b1;
        MemW = 1'b1;
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_val("midrst_flags", Flags, 4'b0000);
        check_val("midrst_regwrite", {3'b0, RegWrite}, 4'd0);
        check_val("midrst_memwrite", {3'b0, MemWrite}, 4'd0);
        step();
        check_val("midrst_hold_regwrite", {3'b0, RegWrite}, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cond_logic.md
# cond_logic

Conditional-execution stage for the multicycle ARM datapath. It sits directly downstream of the microprogrammed control unit and consumes its registered control outputs (RegW, MemW, NextPC, Branch, ALUOp). It holds the architectural NZCV flags and evaluates the instruction's condition field. It gates the state-changing strobes (PCWrite, RegWrite, MemWrite) so that only instructions whose condition passes modify the register file, memory or PC.

## Interface
Parameters: none.
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (asserted at 0)
- Cond  input  4  instruction condition field Instr[31:28], stable while the instruction is held in the IR
- Rd  input  4  destination register Instr[15:12]
- Cmd  input  4  data-processing opcode Instr[24:21]
- S  input  1  set-flags bit Instr[20]
- ALUFlags  input  4  {N,Z,C,V} produced by the ALU this cycle
- RegW, MemW, NextPC, Branch, ALUOp  input  1 each  control-unit strobes
- PCWrite  output  1  gated PC write enable
- RegWrite  output  1  gated register-file write enable
- MemWrite  output  1  gated memory write enable
- Flags  output  4  current architectural {N,Z,C,V}
- CondExQ  output  1  registered condition-pass bit

## Operation
- CondEx is combinational from Cond and the registered Flags:
  - EQ 0000: Z. NE 0001: !Z. CS 0010: C. CC 0011: !C. MI 0100: N. PL 0101: !N. VS 0110: V. VC 0111: !V.
  - HI 1000: C&!Z. LS 1001: !C|Z. GE 1010: N==V. LT 1011: N!=V. GT 1100: !Z&(N==V). LE 1101: Z|(N!=V).
  - AL 1110: 1. Code 1111 is reserved and is treated as 1.
- Flag-write decode:
  - FlagW[1] = ALUOp & S.
  - FlagW[0] = ALUOp & S & (Cmd==0100 ADD or Cmd==0010 SUB).
  - AND/ORR with S set update only N,Z; C,V are preserved.
- Flag registers:
  - Flags[3:2] <= ALUFlags[3:2] when FlagW[1] & CondEx.
  - Flags[1:0] <= ALUFlags[1:0] when FlagW[0] & CondEx.
  - Otherwise the registers hold.
- CondExQ <= CondEx on every rising edge, with no enable.
- PCS = Branch | (RegW & Rd==1111).
- Gated outputs, combinational from registered state and the control inputs:
  - PCWrite = (PCS & CondExQ) | NextPC.
  - RegWrite = RegW & CondExQ.
  - MemWrite = MemW & CondExQ.
- NextPC (fetch increment) is never gated.

## Timing
- Reset asserted: Flags=0000 and CondExQ=0 immediately (asynchronous).
  - Outputs follow: RegWrite=0, MemWrite=0, PCWrite=NextPC.
  - With the control unit in reset, all three are 0.
- Reset deasserted: state updates begin on the first rising edge.
- Flag update latency: ALUFlags sampled in cycle N are visible on Flags in cycle N+1.
- CondEx latency:
  - CondEx evaluated in cycle N (execute, pre-update flags) gates writeback/memory strobes in cycle N+1 via CondExQ.
  - A flag-setting instruction therefore decides its own writeback using its pre-execution flags.
- Simultaneous events:
  - Flag write and CondExQ capture on the same edge both use the pre-edge Flags.
  - The new flags affect CondEx only from the next cycle.
- Condition fails in execute: no flag update. RegWrite, MemWrite and PCS-driven PCWrite stay 0 in the following cycle. NextPC still passes.
- Reset mid-instruction: flags are lost (0000), strobes are forced low at once, and no partial write occurs after reset assertion.
- Inputs ALUFlags and Cond must be stable before the rising edge. There is no internal input registering.

## Test plan
- Reset: hold reset=0 with RegW=MemW=Branch=1 and Cond=1110 → RegWrite=MemWrite=0 and Flags=0000. Release reset, with Cond=1110 for one edge → CondExQ=1 and RegWrite=1.
- ADDS: Cond=1110, ALUOp=1, S=1, Cmd=0100, ALUFlags=0110 for one edge → Flags=0110 next cycle. Then RegW=1 → RegWrite=1.
- ANDS preserves C/V: start with Flags=0011. Apply Cmd=0000, S=1, ALUFlags=1000 → Flags=1011.
- Condition fail: Flags=0000, Cond=0000 (EQ), ALUOp=1, S=1, ALUFlags=0100 for one edge → Flags stay 0000. Next cycle RegW=1, MemW=1 → RegWrite=0 and MemWrite=0. NextPC=1 → PCWrite=1.
- PC write via Rd: Flags=0100, Cond=0000, RegW=1, Rd=1111 → PCWrite=1 one cycle after CondEx is captured. With Cond=0001 → PCWrite=0.
- Signed compare sweep: for each Flags value 0000–1111 and each Cond 0000–1111, CondExQ after one edge matches the condition table (256 checks). Include GE with N=V=1 → 1, and LE with Z=0, N=1, V=0 → 1.
